// File: rtl/m_alu_checker.sv
// Response monitor for m_alu: recomputes the golden result one cycle after sampling,
// flags and counts mismatches, and captures the first failing transaction.
// Optional: define ALU_CHK_HALT_EN to freeze checking after the first mismatch.
module m_alu_checker #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             chk_valid,
  input  logic [WIDTH-1:0] chk_a0,
  input  logic [WIDTH-1:0] chk_a1,
  input  logic [1:0]       chk_ctl,
  input  logic [WIDTH-1:0] chk_out,
  input  logic             chk_zero,
  output logic             pass,
  output logic             fail,
  output logic             err_sticky,
  output logic [CNT_W-1:0] n_checked,
  output logic [CNT_W-1:0] n_errors,
  output logic [WIDTH-1:0] fail_a0,
  output logic [WIDTH-1:0] fail_a1,
  output logic [1:0]       fail_ctl,
  output logic [WIDTH-1:0] fail_out,
  output logic [WIDTH-1:0] fail_exp,
  output logic [1:0]       fail_kind
);

  typedef enum logic [1:0] {
    CLEAN  = 2'd0,
    FAILED = 2'd1,
    HALTED = 2'd2
  } state_e;

  localparam logic [1:0]       CTL_ADD = 2'b00;
  localparam logic [1:0]       CTL_SUB = 2'b01;
  localparam logic [1:0]       CTL_XOR = 2'b10;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a0_q, s1_a0_d;
  logic [WIDTH-1:0] s1_a1_q, s1_a1_d;
  logic [1:0]       s1_ctl_q, s1_ctl_d;
  logic [WIDTH-1:0] s1_out_q, s1_out_d;
  logic             s1_zero_q, s1_zero_d;

  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [CNT_W-1:0] n_checked_q, n_checked_d;
  logic [CNT_W-1:0] n_errors_q, n_errors_d;
  logic [WIDTH-1:0] fail_a0_q, fail_a0_d;
  logic [WIDTH-1:0] fail_a1_q, fail_a1_d;
  logic [1:0]       fail_ctl_q, fail_ctl_d;
  logic [WIDTH-1:0] fail_out_q, fail_out_d;
  logic [WIDTH-1:0] fail_exp_q, fail_exp_d;
  logic [1:0]       fail_kind_q, fail_kind_d;

  logic [WIDTH-1:0] exp_res;
  logic             exp_zero;
  logic             res_mis;
  logic             zero_mis;
  logic             check_en;

  // Golden model evaluated on the stage-1 snapshot.
  always_comb begin
    exp_res = '0;
    unique case (s1_ctl_q)
      CTL_ADD: exp_res = s1_a0_q + s1_a1_q;
      CTL_SUB: exp_res = s1_a0_q - s1_a1_q;
      CTL_XOR: exp_res = s1_a0_q ^ s1_a1_q;
      default: exp_res = {{(WIDTH-1){1'b0}}, ($signed(s1_a0_q) < $signed(s1_a1_q))};
    endcase
    exp_zero = (exp_res == '0);
    res_mis  = (s1_out_q != exp_res);
    zero_mis = (s1_zero_q != exp_zero);
  end

  always_comb begin
    // NOTE: every _d starts from a hold/idle default so no path through this block leaves a latch.
    state_d     = state_q;
    pass_d      = 1'b0;
    fail_d      = 1'b0;
    n_checked_d = n_checked_q;
    n_errors_d  = n_errors_q;
    fail_a0_d   = fail_a0_q;
    fail_a1_d   = fail_a1_q;
    fail_ctl_d  = fail_ctl_q;
    fail_out_d  = fail_out_q;
    fail_exp_d  = fail_exp_q;
    fail_kind_d = fail_kind_q;
    s1_a0_d     = s1_a0_q;
    s1_a1_d     = s1_a1_q;
    s1_ctl_d    = s1_ctl_q;
    s1_out_d    = s1_out_q;
    s1_zero_d   = s1_zero_q;

    check_en = s1_valid_q && (state_q != HALTED);

    if (check_en) begin
      n_checked_d = (&n_checked_q) ? n_checked_q : n_checked_q + CNT_ONE;
      if (res_mis || zero_mis) begin
        fail_d     = 1'b1;
        n_errors_d = (&n_errors_q) ? n_errors_q : n_errors_q + CNT_ONE;
        if (state_q == CLEAN) begin
          fail_a0_d   = s1_a0_q;
          fail_a1_d   = s1_a1_q;
          fail_ctl_d  = s1_ctl_q;
          fail_out_d  = s1_out_q;
          fail_exp_d  = exp_res;
          fail_kind_d = {zero_mis, res_mis};
`ifdef ALU_CHK_HALT_EN
          state_d     = HALTED;
`else
          state_d     = FAILED;
`endif
        end
      end else begin
        pass_d = 1'b1;
      end
    end

    // Entering or sitting in HALTED also drops whatever arrives on this edge.
    s1_valid_d = chk_valid && (state_d != HALTED);
    if (s1_valid_d) begin
      s1_a0_d   = chk_a0;
      s1_a1_d   = chk_a1;
      s1_ctl_d  = chk_ctl;
      s1_out_d  = chk_out;
      s1_zero_d = chk_zero;
    end

    // clear discards the in-flight transaction and any new one on the same edge.
    if (clear) begin
      state_d     = CLEAN;
      s1_valid_d  = 1'b0;
      pass_d      = 1'b0;
      fail_d      = 1'b0;
      n_checked_d = '0;
      n_errors_d  = '0;
      fail_a0_d   = '0;
      fail_a1_d   = '0;
      fail_ctl_d  = '0;
      fail_out_d  = '0;
      fail_exp_d  = '0;
      fail_kind_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAN;
      s1_valid_q  <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      n_checked_q <= '0;
      n_errors_q  <= '0;
      fail_a0_q   <= '0;
      fail_a1_q   <= '0;
      fail_ctl_q  <= '0;
      fail_out_q  <= '0;
      fail_exp_q  <= '0;
      fail_kind_q <= '0;
    end else begin
      state_q     <= state_d;
      s1_valid_q  <= s1_valid_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      n_checked_q <= n_checked_d;
      n_errors_q  <= n_errors_d;
      fail_a0_q   <= fail_a0_d;
      fail_a1_q   <= fail_a1_d;
      fail_ctl_q  <= fail_ctl_d;
      fail_out_q  <= fail_out_d;
      fail_exp_q  <= fail_exp_d;
      fail_kind_q <= fail_kind_d;
    end
  end

  // NOTE: stage-1 data is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_a0_q   <= s1_a0_d;
    s1_a1_q   <= s1_a1_d;
    s1_ctl_q  <= s1_ctl_d;
    s1_out_q  <= s1_out_d;
    s1_zero_q <= s1_zero_d;
  end

  assign pass       = pass_q;
  assign fail       = fail_q;
  assign err_sticky = (state_q != CLEAN);
  assign n_checked  = n_checked_q;
  assign n_errors   = n_errors_q;
  assign fail_a0    = fail_a0_q;
  assign fail_a1    = fail_a1_q;
  assign fail_ctl   = fail_ctl_q;
  assign fail_out   = fail_out_q;
  assign fail_exp   = fail_exp_q;
  assign fail_kind  = fail_kind_q;

endmodule
